// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } state_t;

  // Architectural x0: never a forwarding or load-use source.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding select for one execute-stage operand.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_e_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_m_i,
  input  logic                      reg_write_w_i,
  output fwd_sel_t                  fwd_sel_o
);

  logic match_m;
  logic match_w;

  always_comb begin
    match_m = reg_write_m_i && (rd_m_i != REG_ADDR_WIDTH'(REG_ZERO)) && (rd_m_i == rs_e_i);
    match_w = reg_write_w_i && (rd_w_i != REG_ADDR_WIDTH'(REG_ZERO)) && (rd_w_i == rs_e_i);
    fwd_sel_o = FWD_RF;
    // M holds the younger write, so it wins when both stages match.
    if (match_m) begin
      fwd_sel_o = FWD_M;
    end else if (match_w) begin
      fwd_sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forwarding controller with a data-memory wait FSM.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MAX_WAIT       = 16,
  parameter int unsigned CNT_WIDTH      = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
  input  logic                      LoadE_i,
  input  logic                      RegWriteM_i,
  input  logic                      RegWriteW_i,
  input  logic                      PCSrcE_i,
  input  logic                      MemReqM_i,
  input  logic                      MemAck_i,
  output logic                      StallF_o,
  output logic                      StallD_o,
  output logic                      StallE_o,
  output logic                      StallM_o,
  output logic                      FlushD_o,
  output logic                      FlushE_o,
  output logic                      FlushW_o,
  output logic [1:0]                ForwardAE_o,
  output logic [1:0]                ForwardBE_o,
  output logic                      MemTimeout_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]               StallCycles_o,
  output logic [31:0]               FlushCount_o
`endif
);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  fwd_sel_t               fwd_a, fwd_b;
  logic                   mem_stall;
  logic                   lw_stall;
  logic                   branch_flush;
  logic                   load_use_hit;

  hazard_fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_e_i        (Rs1E_i),
    .rd_m_i        (RdM_i),
    .rd_w_i        (RdW_i),
    .reg_write_m_i (RegWriteM_i),
    .reg_write_w_i (RegWriteW_i),
    .fwd_sel_o     (fwd_a)
  );

  hazard_fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_e_i        (Rs2E_i),
    .rd_m_i        (RdM_i),
    .rd_w_i        (RdW_i),
    .reg_write_m_i (RegWriteM_i),
    .reg_write_w_i (RegWriteW_i),
    .fwd_sel_o     (fwd_b)
  );

  // In MEM_WAIT the stall drops in the ack (or request-withdrawn) cycle so the
  // pipeline advances on the same edge the FSM returns to RUN.
  always_comb begin
    mem_stall    = (((state_q == RUN) || (state_q == MEM_WAIT)) && MemReqM_i && !MemAck_i)
                   || (state_q == FAULT);
    load_use_hit = LoadE_i && (RdE_i != REG_ADDR_WIDTH'(REG_ZERO))
                   && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    branch_flush = PCSrcE_i && !mem_stall;
    lw_stall     = load_use_hit && !PCSrcE_i && !mem_stall;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (MemReqM_i && !MemAck_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_WIDTH'(1);
        end
      end
      MEM_WAIT: begin
        if (MemAck_i || !MemReqM_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_WIDTH'(MAX_WAIT)) begin
          state_d = FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    StallF_o     = 1'b0;
    StallD_o     = 1'b0;
    StallE_o     = 1'b0;
    StallM_o     = 1'b0;
    FlushD_o     = 1'b0;
    FlushE_o     = 1'b0;
    FlushW_o     = 1'b0;
    ForwardAE_o  = FWD_RF;
    ForwardBE_o  = FWD_RF;
    MemTimeout_o = 1'b0;
    if (!rst_n) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
      FlushW_o = 1'b1;
    end else begin
      ForwardAE_o  = fwd_a;
      ForwardBE_o  = fwd_b;
      MemTimeout_o = (state_q == FAULT);
      if (mem_stall) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        StallE_o = 1'b1;
        StallM_o = 1'b1;
        FlushW_o = 1'b1;
      end else if (branch_flush) begin
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
      end else if (lw_stall) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q,  flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (StallF_o && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (rst_n && (FlushD_o || FlushE_o) && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign StallCycles_o = stall_cycles_q;
  assign FlushCount_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus vs a reference model.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int MW = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAck;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [1:0] FwdA, FwdB;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  hazard_ctrl #(.REG_ADDR_WIDTH(AW), .MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
    .LoadE_i(LoadE), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .PCSrcE_i(PCSrcE), .MemReqM_i(MemReqM), .MemAck_i(MemAck),
    .StallF_o(StallF), .StallD_o(StallD), .StallE_o(StallE), .StallM_o(StallM),
    .FlushD_o(FlushD), .FlushE_o(FlushE), .FlushW_o(FlushW),
    .ForwardAE_o(FwdA), .ForwardBE_o(FwdB), .MemTimeout_o(MemTimeout)
`ifdef HAZARD_PERF_EN
    , .StallCycles_o(StallCycles), .FlushCount_o(FlushCount)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: consecutive stalled memory cycles and a sticky fault bit.
  bit  m_fault = 1'b0;
  int  m_waited = 0;
  longint m_stall_cyc = 0;
  longint m_flush_cnt = 0;
  bit  e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fW, e_to;
  int  stall_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_outputs();
    bit busy, hz;
    if (!rst_n) begin
      m_fault = 1'b0; m_waited = 0; m_stall_cyc = 0; m_flush_cnt = 0;
      {e_sF, e_sD, e_sE, e_sM} = 4'b0000;
      {e_fD, e_fE, e_fW} = 3'b111;
      e_to = 1'b0;
    end else begin
      busy = m_fault || (MemReqM && !MemAck);
      hz   = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      e_sF = busy || (!PCSrcE && hz);
      e_sD = e_sF;
      e_sE = busy;
      e_sM = busy;
      e_fW = busy;
      e_fD = !busy && PCSrcE;
      e_fE = !busy && (PCSrcE || hz);
      e_to = m_fault;
    end
    check("StallF", 32'(StallF), 32'(e_sF));
    check("StallD", 32'(StallD), 32'(e_sD));
    check("StallE", 32'(StallE), 32'(e_sE));
    check("StallM", 32'(StallM), 32'(e_sM));
    check("FlushD", 32'(FlushD), 32'(e_fD));
    check("FlushE", 32'(FlushE), 32'(e_fE));
    check("FlushW", 32'(FlushW), 32'(e_fW));
    check("Timeout", 32'(MemTimeout), 32'(e_to));
    check("FwdA", 32'(FwdA), rst_n ? 32'(fwd_ref(Rs1E)) : 32'd0);
    check("FwdB", 32'(FwdB), rst_n ? 32'(fwd_ref(Rs2E)) : 32'd0);
`ifdef HAZARD_PERF_EN
    check("StallCycles", StallCycles, 32'(m_stall_cyc));
    check("FlushCount", FlushCount, 32'(m_flush_cnt));
`endif
  endtask

  // Inputs are set on the falling edge; outputs checked 1 ns later; model advances on the rising edge.
  task automatic tick();
    #1 check_outputs();
    if (StallF) stall_seen++;
    @(posedge clk);
    if (rst_n) begin
      if (e_sF) m_stall_cyc++;
      if (e_fD || e_fE) m_flush_cnt++;
      if (!m_fault) begin
        if (MemReqM && !MemAck) begin
          m_waited++;
          if (m_waited > MW) m_fault = 1'b1;
        end else begin
          m_waited = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAck} = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Forwarding priority and x0 suppression
    RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5;
    #1 check("fwd_m_wins", 32'(FwdA), 32'd2);
    tick();
    RdM = 0;
    #1 check("fwd_w", 32'(FwdA), 32'd1);
    tick();
    RdW = 0;
    #1 check("fwd_rf", 32'(FwdA), 32'd0);
    tick();
    idle_inputs();

    // Load-use, then the same with RdE = x0
    LoadE = 1; RdE = 7; Rs2D = 7;
    #1 check("lw_stallF", 32'(StallF), 32'd1);
    check("lw_flushE", 32'(FlushE), 32'd1);
    tick();
    LoadE = 0;
    #1 check("lw_one_cycle", 32'(StallF), 32'd0);
    tick();
    LoadE = 1; RdE = 0; Rs2D = 0;
    #1 check("lw_x0", 32'(StallF), 32'd0);
    tick();

    // Branch overrides load-use
    RdE = 7; Rs2D = 7; PCSrcE = 1;
    #1 check("br_stallF", 32'(StallF), 32'd0);
    check("br_flushD", 32'(FlushD), 32'd1);
    tick();
    idle_inputs();

    // Memory wait of three cycles, then ack
    MemReqM = 1; MemAck = 0; stall_seen = 0;
    repeat (3) tick();
    MemAck = 1;
    tick();
    check("memwait_stalls", 32'(stall_seen), 32'd3);
    stall_seen = 0;
    repeat (4) tick();
    check("b2b_stalls", 32'(stall_seen), 32'd0);
    idle_inputs();
    tick();

    // Timeout after 17 stalled cycles, sticky until reset
    MemReqM = 1; MemAck = 0;
    repeat (17) tick();
    check("timeout_rise", 32'(MemTimeout), 32'd1);
    MemAck = 1; MemReqM = 0;
    repeat (3) tick();
    check("timeout_sticky", 32'(MemTimeout), 32'd1);
    rst_n = 0;
    tick();
    rst_n = 1;
    idle_inputs();
    tick();
    check("timeout_clear", 32'(MemTimeout), 32'd0);

    // Asynchronous reset in the middle of a wait
    MemReqM = 1; MemAck = 0;
    repeat (3) tick();
    #2 rst_n = 0;
    #1 check("async_flushD", 32'(FlushD), 32'd1);
    check("async_stallF", 32'(StallF), 32'd0);
`ifdef HAZARD_PERF_EN
    check("async_cnt", StallCycles, 32'd0);
`endif
    @(negedge clk);
    tick();
    rst_n = 1; MemReqM = 0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
      Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
      RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
      RdW  = AW'($urandom_range(0, 3));
      LoadE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      PCSrcE = ($urandom_range(0, 3) == 0);
      MemReqM = ($urandom_range(0, 2) != 0);
      MemAck = 1'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
